// File: rtl/pong_field_engine.sv
// pong_field_engine: two-player pong playfield state, per-frame update FSM and pixel colour output.
// Optional ball speed-up is compiled in when the macro PONG_SPEEDUP_EN is defined.
module pong_field_engine #(
    parameter int          H_ACTIVE       = 640,
    parameter int          V_ACTIVE       = 480,
    parameter int          PAD_W          = 4,
    parameter int          PAD_H          = 72,
    parameter int          PAD1_X         = 20,
    parameter int          PAD2_X         = 616,
    parameter int          PAD_VEL        = 3,
    parameter int          BALL_SIZE      = 8,
    parameter int          BALL_VEL       = 2,
    parameter int          VEL_MAX        = 6,
    parameter int          HITS_PER_LEVEL = 4,
    parameter logic [11:0] PAD1_RGB       = 12'h00F,
    parameter logic [11:0] PAD2_RGB       = 12'h0F0,
    parameter logic [11:0] BALL_RGB       = 12'hF00,
    parameter logic [11:0] BG_RGB         = 12'h0FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn,
    input  logic        gra_still,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        graph_on,
    output logic        hit_p1,
    output logic        hit_p2,
    output logic        miss_p1,
    output logic        miss_p2,
    output logic [11:0] graph_rgb
);

    localparam int                 PAD_TOP_MAX  = V_ACTIVE - PAD_H;
    localparam int                 PAD_TOP_INIT = PAD_TOP_MAX / 2;
    localparam logic signed [10:0] SERVE_X      = 11'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic signed [10:0] SERVE_Y      = 11'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic signed [10:0] BOT_Y        = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] INIT_SPD     = 11'(BALL_VEL);

    typedef enum logic [1:0] {ST_WAIT, ST_PAD, ST_BALL, ST_COLL} state_t;

    state_t             state_q, state_d;
    logic               ftick_raw_q, ftick_prev_q, tick;
    logic               pad_step, ball_step, coll_step;
    logic [9:0]         pad1_top, pad2_top;
    logic signed [10:0] ball_x, ball_y, dx, dy;
    logic signed [10:0] spd, spd_new;
    logic               missed;
    logic               y_top, y_bot, hit1, hit2, out1, out2;
    logic               pad1_on, pad2_on, ball_on;

    // Frame tick: rising edge of the registered frame condition, so a held condition updates once.
    always_ff @(posedge clk) begin
        if (reset) begin
            ftick_raw_q  <= 1'b0;
            ftick_prev_q <= 1'b0;
        end else begin
            ftick_raw_q  <= (y == 10'(V_ACTIVE + 1)) && (x == '0);
            ftick_prev_q <= ftick_raw_q;
        end
    end

    assign tick = ftick_raw_q && !ftick_prev_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_WAIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pad_step  = 1'b0;
        ball_step = 1'b0;
        coll_step = 1'b0;
        case (state_q)
            ST_WAIT: if (tick) state_d = ST_PAD;
            ST_PAD: begin
                pad_step = 1'b1;
                state_d  = ST_BALL;
            end
            ST_BALL: begin
                ball_step = 1'b1;
                state_d   = ST_COLL;
            end
            ST_COLL: begin
                coll_step = 1'b1;
                state_d   = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    function automatic logic [9:0] pad_move(input logic [9:0] top, input logic up, input logic dn);
        int t;
        t = int'(top);
        if (dn && !up)      t = (t + PAD_VEL > PAD_TOP_MAX) ? PAD_TOP_MAX : t + PAD_VEL;
        else if (up && !dn) t = (t < PAD_VEL) ? 0 : t - PAD_VEL;
        return 10'(t);
    endfunction

    // Wall test and paddle/exit test are independent chains evaluated on the same ball position.
    always_comb begin
        int bx, by, t1, t2;
        bx    = int'(ball_x);
        by    = int'(ball_y);
        t1    = int'(pad1_top);
        t2    = int'(pad2_top);
        y_top = (by <= 0);
        y_bot = (by + BALL_SIZE >= V_ACTIVE);
        hit1  = (dx < 11'sd0) &&
                (PAD1_X <= bx + BALL_SIZE - 1) && (bx <= PAD1_X + PAD_W - 1) &&
                (by <= t1 + PAD_H - 1) && (by + BALL_SIZE - 1 >= t1);
        hit2  = !hit1 && (dx > 11'sd0) &&
                (PAD2_X <= bx + BALL_SIZE - 1) && (bx <= PAD2_X + PAD_W - 1) &&
                (by <= t2 + PAD_H - 1) && (by + BALL_SIZE - 1 >= t2);
        out1  = !hit1 && !hit2 && (bx + BALL_SIZE <= 0);
        out2  = !hit1 && !hit2 && !out1 && (bx >= H_ACTIVE);
    end

`ifdef PONG_SPEEDUP_EN
    logic [7:0] hit_cnt;
    logic       hit_any;

    assign hit_any = coll_step && !missed && !gra_still && (hit1 || hit2);

    always_comb begin
        spd_new = spd;
        if (hit_any && (int'(hit_cnt) + 1 >= HITS_PER_LEVEL))
            spd_new = (int'(spd) + 1 > VEL_MAX) ? 11'(VEL_MAX) : spd + 11'sd1;
    end

    always_ff @(posedge clk) begin
        if (reset || gra_still) begin
            hit_cnt <= '0;
            spd     <= INIT_SPD;
        end else if (hit_any) begin
            hit_cnt <= (int'(hit_cnt) + 1 >= HITS_PER_LEVEL) ? '0 : hit_cnt + 8'd1;
            spd     <= spd_new;
        end
    end
`else
    assign spd     = INIT_SPD;
    assign spd_new = INIT_SPD;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pad1_top <= 10'(PAD_TOP_INIT);
            pad2_top <= 10'(PAD_TOP_INIT);
            ball_x   <= SERVE_X;
            ball_y   <= SERVE_Y;
            dx       <= -INIT_SPD;
            dy       <= INIT_SPD;
            missed   <= 1'b0;
            hit_p1   <= 1'b0;
            hit_p2   <= 1'b0;
            miss_p1  <= 1'b0;
            miss_p2  <= 1'b0;
        end else begin
            hit_p1  <= 1'b0;
            hit_p2  <= 1'b0;
            miss_p1 <= 1'b0;
            miss_p2 <= 1'b0;
            if (pad_step) begin
                pad1_top <= pad_move(pad1_top, btn[0], btn[1]);
                pad2_top <= pad_move(pad2_top, btn[2], btn[3]);
            end
            if (gra_still) begin
                ball_x <= SERVE_X;
                ball_y <= SERVE_Y;
                dx     <= -INIT_SPD;
                dy     <= INIT_SPD;
                missed <= 1'b0;
            end else if (!missed) begin
                if (ball_step) begin
                    ball_x <= ball_x + dx;
                    ball_y <= ball_y + dy;
                end
                if (coll_step) begin
                    if (y_top) begin
                        ball_y <= '0;
                        dy     <= spd_new;
                    end else if (y_bot) begin
                        ball_y <= BOT_Y;
                        dy     <= -spd_new;
                    end
                    if (hit1) begin
                        dx     <= spd_new;
                        hit_p1 <= 1'b1;
                    end else if (hit2) begin
                        dx     <= -spd_new;
                        hit_p2 <= 1'b1;
                    end else if (out1) begin
                        miss_p1 <= 1'b1;
                        missed  <= 1'b1;
                    end else if (out2) begin
                        miss_p2 <= 1'b1;
                        missed  <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        int px, py, bx, by, t1, t2;
        px      = int'(x);
        py      = int'(y);
        bx      = int'(ball_x);
        by      = int'(ball_y);
        t1      = int'(pad1_top);
        t2      = int'(pad2_top);
        pad1_on = (px >= PAD1_X) && (px <= PAD1_X + PAD_W - 1) && (py >= t1) && (py <= t1 + PAD_H - 1);
        pad2_on = (px >= PAD2_X) && (px <= PAD2_X + PAD_W - 1) && (py >= t2) && (py <= t2 + PAD_H - 1);
        ball_on = (px >= bx) && (px <= bx + BALL_SIZE - 1) && (py >= by) && (py <= by + BALL_SIZE - 1);
        graph_on  = pad1_on || pad2_on || ball_on;
        graph_rgb = '0;
        if (video_on) begin
            if (pad1_on)      graph_rgb = PAD1_RGB;
            else if (pad2_on) graph_rgb = PAD2_RGB;
            else if (ball_on) graph_rgb = BALL_RGB;
            else              graph_rgb = BG_RGB;
        end
    end

endmodule

// File: doc/pong_field_engine.md
# pong_field_engine

Parametrised two-player pong playfield engine: paddle and ball state, per-frame motion and collision FSM, and pixel colour generation for a VGA-style pixel scanner. It sits between the sync generator (`x`, `y`, `video_on`) and the game-control/score FSM (`gra_still`, hit/miss pulses). It generalises the fixed 640×480 pong graphics block:

- screen, paddle, ball, velocity and colour geometry are parameters;
- motion is sequenced by an explicit per-frame update FSM with edge-detected frame tick;
- a miss latches the ball until re-served;
- optional ball speed-up.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `V_ACTIVE`, 480, visible lines
- `PAD_W`, 4, paddle width (px)
- `PAD_H`, 72, paddle height (px)
- `PAD1_X`, 20, paddle 1 left edge
- `PAD2_X`, 616, paddle 2 left edge
- `PAD_VEL`, 3, paddle step per frame
- `BALL_SIZE`, 8, square ball side (px)
- `BALL_VEL`, 2, initial ball speed per axis per frame
- `VEL_MAX`, 6, speed ceiling (speed-up only)
- `HITS_PER_LEVEL`, 4, paddle hits per speed increment (speed-up only)
- `PAD1_RGB` 12'h00F, `PAD2_RGB` 12'h0F0, `BALL_RGB` 12'hF00, `BG_RGB` 12'h0FF, colours

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `btn` in 4: [0] P1 up, [1] P1 down, [2] P2 up, [3] P2 down; level, already debounced
- `gra_still` in 1: hold ball at serve position (new game / game over)
- `video_on` in 1: active display region
- `x`, `y` in 10: current pixel coordinates
- `graph_on` out 1: pixel covered by paddle or ball
- `hit_p1`, `hit_p2` out 1: one-clk pulse, ball returned by that paddle
- `miss_p1`, `miss_p2` out 1: one-clk pulse, ball left through that player's side (P1 left edge, P2 right edge)
- `graph_rgb` out 12: pixel colour

## Operation
- **Frame tick:** `ftick_raw = (y == V_ACTIVE+1) && (x == 0)`, registered; the tick is the rising edge, so exactly one update per frame regardless of pixel-enable rate.
- **FSM:** `WAIT` → (tick) `PAD` → `BALL` → `COLL` → `WAIT`; one state per clk.
- **PAD state:** each paddle independently:
  - down only: top = min(top+`PAD_VEL`, `V_ACTIVE`−`PAD_H`);
  - up only: top = max(top−`PAD_VEL`, 0);
  - both or neither: no move.
- **BALL state:** while not `missed`, x += dx and y += dy. Position and delta registers are 11-bit signed; off-screen values are legal.
- **COLL state:** first match wins.
  1. Top: y ≤ 0 → y = 0, dy = +spd.
  2. Bottom: y+`BALL_SIZE` ≥ `V_ACTIVE` → y = `V_ACTIVE`−`BALL_SIZE`, dy = −spd.
  3. Paddle 1: dx < 0, `PAD1_X` ≤ x+`BALL_SIZE`−1 and x ≤ `PAD1_X`+`PAD_W`−1, y-ranges overlap → dx = +spd, `hit_p1`.
  4. Paddle 2: dx > 0, mirrored test at `PAD2_X` → dx = −spd, `hit_p2`.
  5. Left exit: x+`BALL_SIZE` ≤ 0 → `miss_p1`, set `missed`.
  6. Right exit: x ≥ `H_ACTIVE` → `miss_p2`, set `missed`.
- **Wall and paddle together:** y-wall handling and paddle hit are evaluated in the same `COLL`. The y-wall bounce has no priority over the paddle test.
- **`missed`:** freezes the ball and suppresses all pulses until `gra_still`.
- **`gra_still` high (any state):**
  - ball = ((`H_ACTIVE`−`BALL_SIZE`)/2, (`V_ACTIVE`−`BALL_SIZE`)/2);
  - dx = −`BALL_VEL`, dy = +`BALL_VEL`, spd = `BALL_VEL`;
  - clears `missed` and hit counter; no pulses.
  - Paddles keep moving.
- **Render:** combinational from registered state, zero pixel latency.
  - `video_on` = 0 → 0.
  - Otherwise priority pad1 > pad2 > ball > `BG_RGB`.
  - The ball is a full square.

## Timing
- **Reset values:**
  - paddle tops = (`V_ACTIVE`−`PAD_H`)/2 (204);
  - ball = serve position (316, 236);
  - dx = −2, dy = +2, spd = `BALL_VEL`;
  - state `WAIT`, `missed` = 0, all pulses 0.
- **Pulse latency:** hit/miss pulses are registered, asserted for exactly the one clk following `COLL`, 3 clks after the tick edge.
- **Position visibility:** updates land at the end of the frame's `PAD`/`BALL`/`COLL` cycles, before the next visible line.
- **Reset mid-update:** returns to `WAIT` next clk with reset values; no pulse emitted.
- **Held tick:** a tick held for many clks yields one update. A tick arriving outside `WAIT` is impossible for a ≥4-clk frame.

## Configuration
- **`PONG_SPEEDUP_EN` defined:** a counter increments on each hit. On reaching `HITS_PER_LEVEL` it clears, and spd = min(spd+1, `VEL_MAX`). The new spd applies to the new dx and to |dy| at the next bounce.
- **Undefined:** spd is constant `BALL_VEL`; no counter logic.

## Test plan
- Reset, `gra_still`=1 for 3 frames → ball (316, 236), both paddle tops 204, no pulses, `graph_rgb` = 12'h00F at (21, 240), 12'h0FF at (300, 100), 0 with `video_on`=0.
- `btn[1]` held 80 frames → P1 top reaches 408 and stays; `btn[0]` and `btn[1]` together → top unchanged.
- Bench steers P1 to cover the ball → `hit_p1` one clk, dx = +2; ball y bounce at bottom gives y = 472, dy = −2.
- P1 parked at top 0, ball exits left → single `miss_p1`, ball frozen for 10 frames, no further pulses; `gra_still` pulse → ball back to (316, 236).
- `PONG_SPEEDUP_EN` defined, 4 consecutive hits → \|dx\| = 3; 16 hits → capped at 6. Macro undefined → stays 2.
- Frame condition held 4 clks (pixel enable /4) → exactly one position update and at most one pulse per frame.
